// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that shares one UART transmitter byte port between two
// byte streams, with packet-level grants, burst limiting and a busy timeout.
module uart_tx_arb #(
  parameter logic [15:0] MAX_BURST = 16'd64,
  parameter logic [7:0]  BUSY_TO   = 8'd15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       init_done,
  input  logic       req0,
  input  logic [7:0] data0,
  input  logic       last0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] data1,
  input  logic       last1,
  output logic       ack1,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic [1:0] gnt,
  output logic       to_err
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;
  localparam int unsigned TW = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      gnt_q, gnt_d;
  logic            owner_q, owner_d;
  logic            last_owner_q, last_owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic            last_flag_q, last_flag_d;
  logic            tx_start_q, tx_start_d;
  logic [DW-1:0]   tx_data_q, tx_data_d;
  logic            ack0_q, ack0_d;
  logic            ack1_q, ack1_d;
  logic            to_err_q, to_err_d;

  logic            req_g;
  logic [DW-1:0]   data_g;
  logic            last_g;
  logic            pick;
  logic            byte_done;
  logic            release_now;

  // Inputs of the current owner
  assign req_g  = owner_q ? req1  : req0;
  assign data_g = owner_q ? data1 : data0;
  assign last_g = owner_q ? last1 : last0;

  // A finished byte ends the grant on packet end, burst limit, or loss of init
  assign release_now = last_flag_q || (cnt_q == MAX_BURST) || !init_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      gnt_q        <= 2'b00;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      cnt_q        <= '0;
      to_cnt_q     <= '0;
      last_flag_q  <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      to_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      to_cnt_q     <= to_cnt_d;
      last_flag_q  <= last_flag_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      to_err_q     <= to_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    to_cnt_d     = to_cnt_q;
    last_flag_d  = last_flag_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    to_err_d     = 1'b0;
    pick         = 1'b0;
    byte_done    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (init_done && (req0 || req1)) begin
          // On a tie the requester that did not own the last grant wins
          if (req0 && req1) pick = ~last_owner_q;
          else              pick = req1;
          owner_d = pick;
          gnt_d   = pick ? 2'b10 : 2'b01;
          state_d = S_SEND;
        end
      end

      S_SEND: begin
        if (!req_g) begin
          gnt_d        = 2'b00;
          last_owner_d = owner_q;
          cnt_d        = '0;
          state_d      = S_IDLE;
        end else if (!tx_busy) begin
          tx_start_d  = 1'b1;
          tx_data_d   = data_g;
          ack0_d      = ~owner_q;
          ack1_d      = owner_q;
          cnt_d       = cnt_q + CW'(1);
          last_flag_d = last_g;
          to_cnt_d    = '0;
          state_d     = S_WAIT_BUSY;
        end
      end

      S_WAIT_BUSY: begin
        if (tx_busy) begin
          to_cnt_d = '0;
          state_d  = S_WAIT_DONE;
        end else if (({1'b0, to_cnt_q} + (TW+1)'(1)) >= {1'b0, BUSY_TO}) begin
          to_err_d  = 1'b1;
          to_cnt_d  = '0;
          byte_done = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end

      S_WAIT_DONE: begin
        if (!tx_busy) byte_done = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase

    if (byte_done) begin
      if (release_now) begin
        gnt_d        = 2'b00;
        last_owner_d = owner_q;
        cnt_d        = '0;
        state_d      = S_IDLE;
      end else begin
        state_d = S_SEND;
      end
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign gnt      = gnt_q;
  assign to_err   = to_err_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: byte-queue requesters, a UART busy model and a
// packet-level round-robin model that predicts every transmitted byte.
`timescale 1ns/1ps
module tb_uart_tx_arb;

  localparam int MB  = 4;
  localparam int BTO = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       init_done = 1'b0;
  logic       req0, last0, ack0, req1, last1, ack1;
  logic [7:0] data0, data1, tx_data;
  logic       tx_start, tx_busy, to_err;
  logic [1:0] gnt;

  always #5 clk = ~clk;

  uart_tx_arb #(.MAX_BURST(16'(MB)), .BUSY_TO(8'(BTO))) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .req0(req0), .data0(data0), .last0(last0), .ack0(ack0),
    .req1(req1), .data1(data1), .last1(last1), .ack1(ack1),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .gnt(gnt), .to_err(to_err)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  function automatic void chk(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Requesters: byte queues {last, data}; req is high while a byte is pending
  logic [8:0] mem0 [0:2047];
  logic [8:0] mem1 [0:2047];
  int wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;
  assign req0  = (rd0 != wr0);
  assign data0 = mem0[rd0][7:0];
  assign last0 = mem0[rd0][8];
  assign req1  = (rd1 != wr1);
  assign data1 = mem1[rd1][7:0];
  assign last1 = mem1[rd1][8];

  always @(posedge clk) begin
    if (ack0) rd0 <= rd0 + 1;
    if (ack1) rd1 <= rd1 + 1;
  end

  task automatic put(input int r, input logic [7:0] d, input logic l);
    if (r == 0) begin mem0[wr0] = {l, d}; wr0++; end
    else        begin mem1[wr1] = {l, d}; wr1++; end
  endtask

  // UART: busy for next_b cycles starting the cycle after tx_start
  int rem = 0;
  int next_b = 0;
  assign tx_busy = (rem != 0);
  always @(posedge clk or negedge rst) begin
    if (!rst)          rem <= 0;
    else if (tx_start) rem <= next_b;
    else if (rem != 0) rem <= rem - 1;
  end

  // Packet-level model: expected (owner, byte) for each tx_start
  typedef struct packed { logic own; logic [7:0] d; } exp_t;
  exp_t expq[$];
  int mlo = 1;
  int mp0 = 0, mp1 = 0;

  task automatic predict();
    int g;
    int cnt;
    logic [8:0] b;
    exp_t e;
    while (mp0 != wr0 || mp1 != wr1) begin
      if (mp0 != wr0 && mp1 != wr1) g = (mlo == 0) ? 1 : 0;
      else                          g = (mp0 != wr0) ? 0 : 1;
      cnt = 0;
      forever begin
        if (g == 0) begin b = mem0[mp0]; mp0++; end
        else        begin b = mem1[mp1]; mp1++; end
        e.own = g[0];
        e.d   = b[7:0];
        expq.push_back(e);
        cnt++;
        if (b[8] || cnt == MB || (g == 0 ? mp0 == wr0 : mp1 == wr1)) break;
      end
      mlo = g;
    end
  endtask

  // Per-cycle compare against the model and the timing rules
  bit   nobusy = 0;
  bit   rand_busy = 0;
  int   fixed_b = 10;
  int   n_start = 0;
  int   n_toerr = 0;
  int   prev_start = -1000;
  int   prev_b = 0;
  int   nb;
  int   exp_to;
  logic [7:0] held = 8'h00;
  int   to_exp[$];
  int   log_own[$];
  exp_t e_c;

  always @(negedge clk) begin
    if (!rst) begin
      held       = 8'h00;
      prev_start = -1000;
      prev_b     = 0;
      to_exp.delete();
    end else begin
      chk("gnt_legal", int'(gnt != 2'b11), 1);
      chk("ack_count", int'(ack0) + int'(ack1), int'(tx_start));
      exp_to = (to_exp.size() > 0 && to_exp[0] == cyc) ? 1 : 0;
      chk("to_err_timing", int'(to_err), exp_to);
      if (exp_to == 1) void'(to_exp.pop_front());
      if (to_err) n_toerr++;
      if (!tx_start) begin
        chk("tx_data_hold", int'(tx_data), int'(held));
      end else begin
        n_start++;
        if (expq.size() == 0) begin
          chk("unexpected_start", 1, 0);
        end else begin
          e_c = expq.pop_front();
          chk("start_owner", int'(ack1), int'(e_c.own));
          chk("start_data", int'(tx_data), int'(e_c.d));
          chk("start_gnt", int'(gnt), e_c.own ? 2 : 1);
        end
        if (cyc - prev_start < prev_b + 3)
          chk("start_spacing", cyc - prev_start, prev_b + 3);
        else
          chk("start_spacing", 1, 1 - int'(cyc - prev_start < prev_b + 3));
        nb = nobusy ? 0 : (rand_busy ? int'($urandom_range(1, 6)) : fixed_b);
        next_b = nb;
        if (nb == 0) to_exp.push_back(cyc + BTO);
        prev_b     = nb;
        prev_start = cyc;
        held       = tx_data;
        log_own.push_back(int'(ack1));
      end
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(rd0 == wr0 && rd1 == wr1 && gnt == 2'b00 && !tx_busy && !tx_start) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_timeout"}, int'(n < 3000), 1);
    repeat (4) @(negedge clk);
    chk({name, "_drained"}, expq.size(), 0);
    chk({name, "_gnt_idle"}, int'(gnt), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    mlo = 1;
    expq.delete();
  endtask

  task automatic chk_order(input string name, input int n, input int pat[$]);
    chk({name, "_len"}, log_own.size(), n);
    for (int i = 0; i < n && i < log_own.size(); i++)
      chk(name, log_own[i], pat[i]);
  endtask

  initial begin
    int base;
    int n;
    int run;
    int mx;
    int prv;
    int pat[$];
    int npk;
    int len;

    #1 rst = 1'b0;
    #2;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_tx_start", int'(tx_start), 0);
    chk("rst_ack", int'(ack0) + int'(ack1), 0);
    chk("rst_to_err", int'(to_err), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    init_done = 1'b1;

    // Single byte: grant at t+1, start at t+2
    @(negedge clk);
    base = n_start;
    put(0, 8'hA5, 1'b1);
    predict();
    @(negedge clk);
    chk("t1_gnt_latency", int'(gnt), 1);
    @(negedge clk);
    chk("t1_start", int'(tx_start), 1);
    chk("t1_data", int'(tx_data), 8'hA5);
    chk("t1_ack0", int'(ack0), 1);
    wait_idle("t1");
    chk("t1_one_start", n_start - base, 1);

    // Tie after reset: two-byte packets go 0,0,1,1 twice
    do_reset();
    pat = '{0, 0, 1, 1};
    for (int rep = 0; rep < 2; rep++) begin
      @(negedge clk);
      log_own.delete();
      put(0, 8'h10, 1'b0); put(0, 8'h11, 1'b1);
      put(1, 8'h20, 1'b0); put(1, 8'h21, 1'b1);
      predict();
      wait_idle("t3");
      chk_order("t3_order", 4, pat);
    end

    // Burst limit: 4 bytes each, alternating
    @(negedge clk);
    log_own.delete();
    for (int i = 0; i < 8; i++) begin
      put(0, 8'($urandom), 1'b0);
      put(1, 8'($urandom), 1'b0);
    end
    predict();
    wait_idle("t4");
    pat.delete();
    for (int i = 0; i < 16; i++) pat.push_back((i / 4) % 2);
    chk_order("t4_order", 16, pat);
    run = 0; mx = 0; prv = -1;
    foreach (log_own[i]) begin
      run = (log_own[i] == prv) ? run + 1 : 1;
      prv = log_own[i];
      if (run > mx) mx = run;
    end
    chk("t4_max_run", mx, MB);

    // init_done gating
    @(negedge clk);
    init_done = 1'b0;
    base = n_start;
    put(0, 8'h31, 1'b0); put(0, 8'h32, 1'b0); put(0, 8'h33, 1'b1);
    n = 0;
    repeat (100) begin
      @(negedge clk);
      if (gnt != 2'b00 || tx_start) n++;
    end
    chk("t5_gated", n, 0);
    chk("t5_gated_starts", n_start - base, 0);
    e_c.own = 1'b0; e_c.d = 8'h31;
    expq.push_back(e_c);
    mp0++;
    init_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t5_start_after_init", int'(tx_start), 1);
    chk("t5_data", int'(tx_data), 8'h31);
    init_done = 1'b0;
    repeat (40) @(negedge clk);
    chk("t5_single_byte", n_start - base, 1);
    chk("t5_released", int'(gnt), 0);
    mlo = 0;
    init_done = 1'b1;
    predict();
    wait_idle("t5b");

    // No busy: to_err BTO cycles after each start, then continue
    @(negedge clk);
    nobusy = 1;
    base = n_toerr;
    put(0, 8'h41, 1'b0); put(0, 8'h42, 1'b1);
    predict();
    wait_idle("t6");
    chk("t6_to_err_count", n_toerr - base, 2);
    nobusy = 0;

    // Randomized rounds
    rand_busy = 1;
    for (int r = 0; r < 25; r++) begin
      @(negedge clk);
      for (int q = 0; q < 2; q++) begin
        npk = int'($urandom_range(0, 3));
        for (int p = 0; p < npk; p++) begin
          len = int'($urandom_range(1, 6));
          for (int b = 0; b < len; b++)
            put(q, 8'($urandom), (b == len - 1) && ($urandom_range(0, 4) != 0));
        end
      end
      predict();
      wait_idle("rand");
    end
    rand_busy = 0;

    // Reset while waiting for the byte to finish
    @(negedge clk);
    put(0, 8'h55, 1'b1);
    predict();
    n = 0;
    while (!tx_start && n < 20) begin @(negedge clk); n++; end
    chk("t8_start_seen", int'(tx_start), 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t8_rst_gnt", int'(gnt), 0);
    chk("t8_rst_tx_start", int'(tx_start), 0);
    chk("t8_rst_ack", int'(ack0) + int'(ack1), 0);
    chk("t8_rst_to_err", int'(to_err), 0);
    chk("t8_rst_tx_data", int'(tx_data), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    mlo = 1;
    expq.delete();
    @(negedge clk);
    log_own.delete();
    put(0, 8'h66, 1'b1);
    put(1, 8'h77, 1'b1);
    predict();
    wait_idle("t8");
    pat = '{0, 1};
    chk_order("t8_order", 2, pat);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Shares one UART transmitter byte interface between two acquisition byte streams (requester 0, requester 1).
- Grants are round-robin at packet granularity. A grant is held until the requester flags its last byte, drops its request, or reaches MAX_BURST bytes.
- Gated by the init controller's done flag, so no byte leaves before the baud words are latched.

Parameters:
- MAX_BURST, 16'd64, maximum bytes per grant before forced release. Legal range 1..65535.
- BUSY_TO, 8'd15, cycles to wait for tx_busy to rise after tx_start before declaring a timeout.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- init_done  input  1  high when UART baud setup is complete; level-sensitive
- req0  input  1  requester 0 has a valid byte on data0
- data0  input  8  requester 0 byte
- last0  input  1  qualifies data0 as the final byte of the packet
- ack0  output  1  one-cycle pulse: data0/last0 consumed
- req1, data1, last1, ack1: same as above, for requester 1
- tx_start  output  1  one-cycle pulse to the UART transmitter
- tx_data  output  8  byte to transmit; valid with tx_start, held until next tx_start
- tx_busy  input  1  UART busy; rises 1 cycle after tx_start, low when the byte is finished
- gnt  output  2  one-hot current owner; 2'b00 when idle
- to_err  output  1  one-cycle pulse on busy timeout

Behaviour:
- Reset (rst low, asynchronous): state IDLE; ack0, ack1, tx_start, to_err = 0; tx_data = 8'h00; gnt = 2'b00; byte counter = 0; last_owner = 1, so requester 0 wins the first tie. A reset mid-transfer aborts immediately; no ack is issued.
- All outputs are registered.

FSM states and transitions:
- IDLE
  - Stay while !init_done or no request.
  - Single request: grant that requester.
  - Both requesting: grant the requester that is not last_owner.
  - On grant: set gnt, go to SEND.
- SEND
  - If req[g] is low: release (gnt=0, last_owner=g, count=0) and go to IDLE. No byte is sent.
  - Else if !tx_busy: next cycle tx_start=1, tx_data=data[g], ack[g]=1, count+=1, latch last[g] into a last_flag. Go to WAIT_BUSY.
  - Else (tx_busy high): stay.
- WAIT_BUSY
  - tx_busy high: go to WAIT_DONE, clear the timeout counter.
  - Otherwise the timeout counter increments. When it reaches BUSY_TO: pulse to_err and treat the byte as finished (same exit rules as WAIT_DONE).
- WAIT_DONE
  - Wait for tx_busy low, then:
    - If last_flag, or count==MAX_BURST, or !init_done: release to IDLE (gnt=0, last_owner=g, count=0).
    - Otherwise go to SEND.

Timing and handshake rules:
- Latency: req0 high at cycle t in IDLE with tx idle gives gnt=01 at t+1, then tx_start/ack0 at t+2.
- Minimum spacing between tx_start pulses is 3 cycles plus the UART busy time.
- Requester contract: after ack, present the next byte (or drop req) by the next SEND evaluation. data/last must be stable while req is high and no ack has been received.
- The arbiter never pulses ack without tx_start in the same cycle. ack0 and ack1 are never both high.

Boundary conditions:
- A request arriving during another's grant waits; round-robin applies at release.
- init_done falling mid-byte: the current byte completes, then the grant is released. No new grant while it is low.
- MAX_BURST=1: release after every byte, so the two requesters strictly alternate.
- The counter never wraps; it is cleared on every release.
- A req drop during WAIT_* is ignored until the next SEND.

Test Plan:
- init_done=1, req0 with data0=8'hA5, last0=1; UART model busy 10 cycles -> tx_start at t+2 with tx_data=A5, ack0 coincident; gnt returns to 00 after busy falls; exactly one tx_start.
- req0 and req1 both high from the same cycle, each sending 2-byte packets (last on byte 2) -> order is 0,0,1,1. Repeat the packets -> order is 0,0,1,1 again (alternates).
- MAX_BURST=4, req0 held high with last0=0, req1 high -> 4 bytes from requester 0, then 4 from requester 1, alternating; never 5 consecutive acks to one requester.
- init_done=0 with req0 high for 100 cycles -> no tx_start, gnt=00. Raise init_done -> first tx_start 2 cycles later. Drop init_done mid-burst -> the current byte finishes, then no further tx_start.
- UART model never raises tx_busy -> to_err pulses BUSY_TO cycles after each tx_start; the arbiter proceeds to the next byte.
- Assert rst low while in WAIT_DONE -> all outputs 0 asynchronously. After release, a tie goes to requester 0.
